// File: rtl/softmax_pkg.sv
// ============================================================================
// Module   : softmax_pkg
// Purpose  : Shared types, constants and fp32 ordering helper for the softmax
//            stream loader and its max tracker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package softmax_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PAD  = 2'd2,
        DONE = 2'd3
    } state_t;

    // fp32 negative infinity, the fill word that makes exp() contribute 0
    localparam logic [31:0] FP32_NEG_INF = 32'hFF80_0000;

    // Map an fp32 bit pattern onto an unsigned key whose integer order matches
    // the float order (-0 sits just below +0; NaNs land beyond the infinities).
    function automatic logic [31:0] fp32_key(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp32_max_tracker.sv
// ============================================================================
// Module   : fp32_max_tracker
// Purpose  : Running fp32 maximum. Seed loads the first word of a frame,
//            update keeps the larger of the stored word and the new word,
//            reset clears the register to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp32_max_tracker
    import softmax_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_seed,
    input  logic        i_update,
    input  logic [31:0] i_data,
    output logic [31:0] o_max
);

    logic [31:0] r_max;
    logic        w_greater;

    assign w_greater = (fp32_key(i_data) > fp32_key(r_max));
    assign o_max     = r_max;

    // Seed takes priority so a new frame never compares against the old max
    always_ff @(posedge clk) begin
        if (rst) begin
            r_max <= 32'h0000_0000;
        end else if (i_seed) begin
            r_max <= i_data;
        end else if (i_update && w_greater) begin
            r_max <= i_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/softmax_stream_loader.sv
// ============================================================================
// Module   : softmax_stream_loader
// Purpose  : Accepts one frame of fp32 logits over valid/ready, writes it to
//            RAM1 port A at addresses 0..TOTAL_WORDS-1, pads short frames with
//            PAD_VALUE and flags the completed buffer to the control unit.
//            Optional frame maximum tracking: define SOFTMAX_MAX_TRACK_EN.
//            With the macro, DATA_WIDTH must be 32.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module softmax_stream_loader
    import softmax_pkg::*;
#(
    parameter int unsigned           TOTAL_WORDS = 1024,
    parameter int unsigned           DATA_WIDTH  = 32,
    parameter int unsigned           ADDR_WIDTH  = 10,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE   = 32'hFF80_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  ram_en,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  frame_valid,
    input  logic                  frame_ack,
    output logic [ADDR_WIDTH:0]   frame_count,
    output logic [DATA_WIDTH-1:0] frame_max,
    output logic                  err_short,
    output logic                  err_long
);

    localparam int unsigned      CW         = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]    c_LAST_IDX = CW'(TOTAL_WORDS - 1);

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_in_ready;
    logic                  r_ram_en;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [DATA_WIDTH-1:0] r_ram_data;
    logic                  r_frame_valid;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_pad_ptr;
    logic                  r_err_short;
    logic                  r_err_long;

    logic                  w_accept;
    logic                  w_first;
    logic [CW-1:0]         w_idx;
    logic                  w_at_end;
    logic                  w_pad_end;
    logic                  w_ram_wr;
    logic [ADDR_WIDTH-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_data;

    // A beat is taken only when the registered ready was high in this cycle
    assign w_accept  = in_valid & r_in_ready;
    assign w_first   = w_accept & (r_state == IDLE);
    // Index of the incoming beat: IDLE always writes slot 0 of a fresh frame
    assign w_idx     = (r_state == IDLE) ? '0 : r_count;
    assign w_at_end  = (w_idx == c_LAST_IDX);
    assign w_pad_end = (r_pad_ptr == c_LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and write-port selection
    always_comb begin
        w_state_next = r_state;
        w_ram_wr     = 1'b0;
        w_ram_addr   = w_idx[ADDR_WIDTH-1:0];
        w_ram_data   = in_data;
        case (r_state)
            IDLE, LOAD: begin
                if (w_accept) begin
                    w_ram_wr = 1'b1;
                    if (w_at_end) begin
                        w_state_next = DONE;
                    end else if (in_last) begin
                        w_state_next = PAD;
                    end else begin
                        w_state_next = LOAD;
                    end
                end
            end
            PAD: begin
                w_ram_wr   = 1'b1;
                w_ram_addr = r_pad_ptr[ADDR_WIDTH-1:0];
                w_ram_data = PAD_VALUE;
                if (w_pad_end) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                // Ack only counts once frame_valid is actually visible
                if (frame_ack && r_frame_valid) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Registered outputs, frame bookkeeping and pad pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready    <= 1'b0;
            r_ram_en      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_data    <= '0;
            r_frame_valid <= 1'b0;
            r_count       <= '0;
            r_pad_ptr     <= '0;
            r_err_short   <= 1'b0;
            r_err_long    <= 1'b0;
        end else begin
            r_in_ready    <= (w_state_next == IDLE) || (w_state_next == LOAD);
            r_ram_en      <= w_ram_wr;
            // frame_valid trails DONE entry by one cycle so RAM1 holds the last word
            r_frame_valid <= (r_state == DONE) && !(frame_ack && r_frame_valid);
            if (w_ram_wr) begin
                r_ram_addr <= w_ram_addr;
                r_ram_data <= w_ram_data;
            end
            if (w_first) begin
                r_err_short <= 1'b0;
                r_err_long  <= 1'b0;
            end
            if (w_accept) begin
                r_count <= w_idx + 1'b1;
                if (w_at_end) begin
                    r_err_long <= ~in_last;
                end else if (in_last) begin
                    r_err_short <= 1'b1;
                    r_pad_ptr   <= w_idx + 1'b1;
                end
            end
            if (r_state == PAD) begin
                r_pad_ptr <= r_pad_ptr + 1'b1;
            end
        end
    end

`ifdef SOFTMAX_MAX_TRACK_EN
    fp32_max_tracker u_max (
        .clk      (clk),
        .rst      (rst),
        .i_seed   (w_first),
        .i_update (w_accept & ~w_first),
        .i_data   (in_data),
        .o_max    (frame_max)
    );
`else
    assign frame_max = '0;
`endif

    assign in_ready    = r_in_ready;
    assign ram_en      = r_ram_en;
    assign ram_wr_en   = r_ram_en;
    assign ram_addr    = r_ram_addr;
    assign ram_data    = r_ram_data;
    assign frame_valid = r_frame_valid;
    assign frame_count = r_count;
    assign err_short   = r_err_short;
    assign err_long    = r_err_long;

endmodule

`default_nettype wire

// File: tb/tb_softmax_stream_loader.sv
// ============================================================================
// Module   : tb_softmax_stream_loader
// Purpose  : Directed self-checking bench for softmax_stream_loader with a
//            behavioural RAM1 stand-in. Expected frame_max depends on
//            SOFTMAX_MAX_TRACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_softmax_stream_loader;

`ifdef SOFTMAX_MAX_TRACK_EN
    localparam logic [31:0] E_MAX_FULL  = 32'h447F_C000;
    localparam logic [31:0] E_MAX_SHORT = 32'h3F80_0000;
`else
    localparam logic [31:0] E_MAX_FULL  = 32'h0000_0000;
    localparam logic [31:0] E_MAX_SHORT = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        ram_en;
    logic        ram_wr_en;
    logic [9:0]  ram_addr;
    logic [31:0] ram_data;
    logic        frame_valid;
    logic        frame_ack = 1'b0;
    logic [10:0] frame_count;
    logic [31:0] frame_max;
    logic        err_short;
    logic        err_long;

    logic [31:0] mem [1024];

    int checks   = 0;
    int failures = 0;
    int bad;
    int n;

    softmax_stream_loader dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .ram_en      (ram_en),
        .ram_wr_en   (ram_wr_en),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .frame_count (frame_count),
        .frame_max   (frame_max),
        .err_short   (err_short),
        .err_long    (err_long)
    );

    always #5 clk = ~clk;

    // RAM1 port A stand-in
    always @(posedge clk) begin
        if (ram_en && ram_wr_en) mem[ram_addr] <= ram_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (frame_valid !== 1'b1 && cycles < 2000) begin
            step();
            cycles++;
        end
    endtask

    task automatic ack();
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        chk("ack_valid_drop", frame_valid, 0);
        chk("ack_ready_back", in_ready, 1);
    endtask

    // Non-negative integer to fp32 (exact for values below 2^24)
    function automatic logic [31:0] to_fp32(input int v);
        int          p;
        logic [31:0] m;
        if (v == 0) return 32'h0;
        p = 0;
        for (int b = 0; b < 31; b++) if (v[b]) p = b;
        m = 32'(v) << (23 - p);
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    initial begin
        // ---- reset ----
        step();
        step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_count", frame_count, 0);
        chk("rst_frame_max", frame_max, 0);
        rst = 1'b0;
        step();
        chk("rst_release_ready", in_ready, 1);

        // ---- full frame: 0.0 .. 1023.0 ----
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            send(to_fp32(i), i == 1023);
            if (!(ram_en === 1'b1 && ram_wr_en === 1'b1 && ram_addr === 10'(i)
                  && ram_data === to_fp32(i))) bad++;
        end
        chk("full_write_seq_errors", bad, 0);
        chk("full_valid_not_yet", frame_valid, 0);
        chk("full_ready_done", in_ready, 0);
        step();
        chk("full_frame_valid", frame_valid, 1);
        chk("full_ram_idle", ram_en, 0);
        chk("full_count", frame_count, 1024);
        chk("full_max", frame_max, E_MAX_FULL);
        chk("full_err_short", err_short, 0);
        chk("full_err_long", err_long, 0);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== to_fp32(i)) bad++;
        chk("full_mem_errors", bad, 0);
        ack();

        // ---- short frame {1.0, -2.0, 0.5} ----
        send(32'h3F80_0000, 1'b0);
        send(32'hC000_0000, 1'b0);
        send(32'h3F00_0000, 1'b1);
        chk("short_ready_pad", in_ready, 0);
        wait_valid(n);
        chk("short_valid_latency", n, 1022);
        chk("short_err_short", err_short, 1);
        chk("short_err_long", err_long, 0);
        chk("short_count", frame_count, 3);
        chk("short_max", frame_max, E_MAX_SHORT);
        bad = 0;
        if (mem[0] !== 32'h3F80_0000 || mem[1] !== 32'hC000_0000 || mem[2] !== 32'h3F00_0000) bad++;
        for (int i = 3; i < 1024; i++) if (mem[i] !== 32'hFF80_0000) bad++;
        chk("short_mem_errors", bad, 0);
        ack();

        // ---- long frame: 1024 beats without in_last, then a 1025th ----
        for (int i = 0; i < 1024; i++) send(to_fp32(i), 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h8000_0000;
        in_last  = 1'b0;
        chk("long_ready_done", in_ready, 0);
        step();
        chk("long_frame_valid", frame_valid, 1);
        chk("long_err_long", err_long, 1);
        chk("long_err_short", err_short, 0);
        chk("long_count", frame_count, 1024);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (frame_valid !== 1'b1 || ram_en !== 1'b0 || in_ready !== 1'b0) bad++;
        end
        chk("long_hold_errors", bad, 0);
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
        chk("long_ack_valid_drop", frame_valid, 0);
        chk("long_ack_ready", in_ready, 1);
        chk("long_ack_beat_not_taken", ram_en, 0);
        step();
        chk("carry_beat_en", ram_en, 1);
        chk("carry_beat_addr", ram_addr, 0);
        chk("carry_beat_data", ram_data, 32'h8000_0000);
        chk("carry_count", frame_count, 1);
        chk("carry_err_long_clr", err_long, 0);

        // ---- sign ordering {-0.0, -5.0, +0.0, -inf} with stalls ----
        in_valid = 1'b0;
        step();
        chk("stall_no_write", ram_en, 0);
        step();
        send(32'hC0A0_0000, 1'b0);
        step();
        send(32'h0000_0000, 1'b0);
        send(32'hFF80_0000, 1'b1);
        chk("sign_last_addr", ram_addr, 3);
        wait_valid(n);
        chk("sign_valid_latency", n, 1021);
        chk("sign_max", frame_max, 32'h0000_0000);
        chk("sign_count", frame_count, 4);
        chk("sign_err_short", err_short, 1);
        chk("sign_mem0", mem[0], 32'h8000_0000);
        chk("sign_mem1", mem[1], 32'hC0A0_0000);
        chk("sign_mem4_pad", mem[4], 32'hFF80_0000);
        ack();

        // ---- reset mid-frame ----
        for (int i = 0; i < 500; i++) send(to_fp32(i), 1'b0);
        chk("mid_count", frame_count, 500);
        rst = 1'b1;
        step();
        chk("mid_rst_ready", in_ready, 0);
        chk("mid_rst_ram_en", ram_en, 0);
        chk("mid_rst_addr", ram_addr, 0);
        chk("mid_rst_count", frame_count, 0);
        chk("mid_rst_max", frame_max, 0);
        chk("mid_rst_errs", {err_short, err_long, frame_valid}, 0);
        rst = 1'b0;
        step();
        chk("mid_release_ready", in_ready, 1);
        send(32'h40E0_0000, 1'b0);
        chk("mid_new_addr", ram_addr, 0);
        chk("mid_new_data", ram_data, 32'h40E0_0000);
        chk("mid_new_count", frame_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/softmax_stream_loader.md
# softmax_stream_loader

Streaming front-end for the pipelined softmax core. Accepts one frame of fp32 logits over a valid/ready stream and writes it into the core's input buffer (RAM1 port A) as a contiguous 0..TOTAL_WORDS-1 block. Pads short frames with -inf so they contribute exp = 0, and tracks the frame maximum in fp32. Raises `frame_valid` to the control unit when the buffer is complete.

## Interface
- `TOTAL_WORDS`, 1024, words per frame (1..2^ADDR_WIDTH)
- `DATA_WIDTH`, 32, word width (fp32)
- `ADDR_WIDTH`, 10, RAM1 address width
- `PAD_VALUE`, 32'hFF80_0000, fill word for short frames (-inf)

Ports:
- `clk` in 1: sole clock, rising edge
- `rst` in 1: reset, synchronous, active-high
- `in_valid` in 1: input beat valid
- `in_ready` out 1: loader can accept a beat
- `in_data` in DATA_WIDTH: fp32 logit
- `in_last` in 1: final beat of frame
- `ram_en` out 1: drives RAM1 `data_in_enable`
- `ram_wr_en` out 1: drives RAM1 `data_in_wr_enable`
- `ram_addr` out ADDR_WIDTH: drives RAM1 `data_in_address`
- `ram_data` out DATA_WIDTH: drives RAM1 `data_in`
- `frame_valid` out 1: buffer complete; held until ack
- `frame_ack` in 1: control unit has taken the frame
- `frame_count` out ADDR_WIDTH+1: real (non-pad) words in the frame
- `frame_max` out DATA_WIDTH: fp32 max of the real words (only with `SOFTMAX_MAX_TRACK_EN`)
- `err_short` out 1: `in_last` arrived before word TOTAL_WORDS
- `err_long` out 1: word TOTAL_WORDS arrived without `in_last`

## Operation
States:
- **IDLE**
  - `in_ready`=1.
  - On an accepted beat: write it at address 0, set count=1, clear errors, seed max, go to LOAD.
  - If that beat completes the frame: go straight to PAD or DONE using the LOAD rules.
- **LOAD**
  - `in_ready`=1. Each accepted beat is written at address = count, then count++.
  - Beat at count = TOTAL_WORDS-1 → DONE.
    - If `in_last`=0 on that beat: set `err_long`.
    - Further beats are not consumed by this frame.
  - Beat with `in_last`=1 and count < TOTAL_WORDS-1 → PAD; set `err_short`.
- **PAD**
  - `in_ready`=0. Writes PAD_VALUE to one address per cycle, up to TOTAL_WORDS-1, then → DONE.
  - Pad words do not change `frame_count` or `frame_max`.
- **DONE**
  - `in_ready`=0, `frame_valid`=1.
  - `frame_ack`=1 → IDLE.

Data rules:
- Max ordering uses the key `sign ? ~x : x | 32'h8000_0000`, compared as unsigned.
  - This orders -0 below +0.
  - Positive NaN ranks above +inf; negative NaN ranks below -inf. No special casing.
- Max is seeded with the first real word of the frame.
- `frame_count`, `frame_max` and the error flags are stable from the DONE entry until the next frame's first accepted beat.
- `frame_ack` outside DONE is ignored.

## Timing
- Reset values:
  - All outputs 0, except `in_ready`=1 one cycle after reset deasserts.
  - State is IDLE, count is 0.
- Write latency: a beat accepted at edge k appears on `ram_en`/`ram_wr_en`/`ram_addr`/`ram_data` (all registered) in cycle k..k+1. RAM1 captures it at edge k+1.
- Throughput: one beat per cycle. PAD writes one word per cycle.
- `frame_valid` rises the cycle after the final write cycle, so RAM1 already holds the word.
- `frame_ack` at edge e → `frame_valid`=0 and `in_ready`=1 after e. A beat presented in the same cycle as the ack is not accepted.
- `ram_en` and `ram_wr_en` are low in every cycle without a write.
- Reset mid-frame: outputs and state return to reset values at the next edge. The partial frame is discarded and RAM contents are untouched.
- TOTAL_WORDS=1: every accepted beat goes IDLE→DONE.

## Configuration
- `SOFTMAX_MAX_TRACK_EN` defined:
  - Key compare and max register are built.
  - `frame_max` is a live port.
- Not defined:
  - `frame_max` is driven to constant 32'h0000_0000; no compare logic is built.
  - All other behaviour is identical.

## Structure
- Shared package `softmax_pkg`:
  - State enum: IDLE, LOAD, PAD, DONE.
  - `FP32_NEG_INF` = 32'hFF80_0000.
  - Key-transform function for fp32 ordering.
- One sub-module, `fp32_max_tracker`: key compare plus register with seed/update/clear. It is instantiated only under `SOFTMAX_MAX_TRACK_EN`.

## Test plan
- Full frame (TOTAL_WORDS=1024):
  - Stimulus: 1024 beats back-to-back, data = address as fp32, `in_last` on beat 1024.
  - Response: RAM1 holds 0.0..1023.0, `frame_valid` one cycle after the last write, `frame_count`=1024, `frame_max`=32'h447F_C000, no errors.
- Short frame:
  - Stimulus: 3 beats {1.0, -2.0, 0.5}, `in_last` on the 3rd.
  - Response: addresses 3..1023 = 32'hFF80_0000, `err_short`=1, `frame_count`=3, `frame_max`=32'h3F80_0000.
- Long frame:
  - Stimulus: 1025 beats, no `in_last`.
  - Response: `err_long`=1, `in_ready`=0 in DONE, 1025th beat not accepted until after `frame_ack`.
- Sign ordering:
  - Stimulus: frame of {-0.0, -5.0, +0.0, -inf}.
  - Response: `frame_max`=32'h0000_0000. Without the macro, `frame_max`=0 throughout.
- Backpressure and ack:
  - Stimulus: `in_valid` toggled randomly, `frame_ack` held off 10 cycles, then asserted together with `in_valid`.
  - Response: `frame_valid` held for 10 cycles, the concurrent beat is not accepted, and it is written at address 0 of the next frame.
- Reset mid-frame:
  - Stimulus: `rst` after 500 beats.
  - Response: next cycle has all outputs 0 and state IDLE. A new frame starts at address 0 with `frame_count` restarting at 1.
